// File: rtl/multicycle_main_control_pkg.sv
// Shared constants for the multi-cycle core control path: opcodes, ALUOp
// encodings, ALU B-operand selects and the main FSM state encoding.
package multicycle_main_control_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALUOp as consumed by the ALU-control decoder
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    // ALU B-operand mux selects
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8
    } state_t;

endpackage

// File: rtl/multicycle_main_control_wait_timer.sv
// Bounded-wait counter: counts cycles spent waiting on memory and flags the
// last permitted cycle so the FSM can abort instead of hanging.
module mc_wait_timer #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_en,
    output logic             expired,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over count so a state change or abort always restarts at 0
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (count_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign expired = (r_cnt == CNT_W'(WAIT_LIMIT - 1));
    assign cnt     = r_cnt;

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle RISC-V core: sequences fetch, decode,
// execute, memory and writeback phases and drives datapath enables/selects.
module multicycle_main_control
    import multicycle_main_control_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       pc_source,
    output logic       instr_done,
    output logic       illegal_instr,
    output logic       mem_timeout,
    output logic [3:0] state_o
);

    state_t           r_state;
    state_t           w_next;
    logic             w_in_wait;
    logic             w_expired;
    logic             w_timeout;
    logic             w_clear;
    logic [CNT_W-1:0] w_wait_cnt;
    logic             w_unused_cnt;

    assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                       (r_state == S_MEM_WRITE);
    // mem_ready on the limit cycle counts as completion, not as an abort
    assign w_timeout = w_in_wait && !mem_ready && w_expired;
    // A FETCH timeout keeps the state, so the abort must clear explicitly
    assign w_clear   = (w_next != r_state) || w_timeout;

    mc_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT),
        .CNT_W     (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .count_en(w_in_wait && !mem_ready),
        .expired (w_expired),
        .cnt     (w_wait_cnt)
    );

    // Raw count is only a debug aid; the FSM relies on the expired flag
    assign w_unused_cnt = ^w_wait_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode; reset forces every output low
    always_comb begin
        w_next        = r_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        pc_source     = 1'b0;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        mem_timeout   = 1'b0;
        state_o       = r_state;

        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_timeout) begin
                    mem_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                // Branch target PC + imm is parked in ALUOut here
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
                    OP_RTYPE:          w_next = S_EXEC_R;
                    OP_BRANCH:         w_next = S_BRANCH;
                    default: begin
                        illegal_instr = 1'b1;
                        w_next        = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEM_WB;
                end else if (w_timeout) begin
                    mem_timeout = 1'b1;
                    w_next      = S_FETCH;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end else if (w_timeout) begin
                    mem_timeout = 1'b1;
                    w_next      = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNC;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_RS2;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                instr_done    = 1'b1;
                w_next        = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            pc_source     = 1'b0;
            instr_done    = 1'b0;
            illegal_instr = 1'b0;
            mem_timeout   = 1'b0;
            state_o       = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed self-checking bench for the multi-cycle main control FSM.
module tb_multicycle_main_control;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, alu_src_a, pc_source;
    logic       instr_done, illegal_instr, mem_timeout;
    logic [1:0] alu_src_b, alu_op;
    logic [3:0] state_o;

    int checks   = 0;
    int failures = 0;

    // Output bundle, MSB first:
    // pcw pcwc iord mrd mwr irw m2r rw srca | srcb[2] | aluop[2] | pcsrc done ill tmo
    logic [16:0] obs_vec;
    assign obs_vec = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, instr_done, illegal_instr, mem_timeout};

    localparam logic [16:0] E_ZERO        = 17'b0_0_0_0_0_0_0_0_0_00_00_0_0_0_0;
    localparam logic [16:0] E_FETCH_RDY   = 17'b1_0_0_1_0_1_0_0_0_01_00_0_0_0_0;
    localparam logic [16:0] E_FETCH_WAIT  = 17'b0_0_0_1_0_0_0_0_0_01_00_0_0_0_0;
    localparam logic [16:0] E_FETCH_TMO   = 17'b0_0_0_1_0_0_0_0_0_01_00_0_0_0_1;
    localparam logic [16:0] E_DECODE      = 17'b0_0_0_0_0_0_0_0_0_10_00_0_0_0_0;
    localparam logic [16:0] E_DECODE_ILL  = 17'b0_0_0_0_0_0_0_0_0_10_00_0_0_1_0;
    localparam logic [16:0] E_MEM_ADDR    = 17'b0_0_0_0_0_0_0_0_1_10_00_0_0_0_0;
    localparam logic [16:0] E_MEM_READ    = 17'b0_0_1_1_0_0_0_0_0_00_00_0_0_0_0;
    localparam logic [16:0] E_MEM_RD_TMO  = 17'b0_0_1_1_0_0_0_0_0_00_00_0_0_0_1;
    localparam logic [16:0] E_MEM_WB      = 17'b0_0_0_0_0_0_1_1_0_00_00_0_1_0_0;
    localparam logic [16:0] E_MEM_WR_WAIT = 17'b0_0_1_0_1_0_0_0_0_00_00_0_0_0_0;
    localparam logic [16:0] E_MEM_WR_RDY  = 17'b0_0_1_0_1_0_0_0_0_00_00_0_1_0_0;
    localparam logic [16:0] E_EXEC_R      = 17'b0_0_0_0_0_0_0_0_1_00_10_0_0_0_0;
    localparam logic [16:0] E_R_WB        = 17'b0_0_0_0_0_0_0_1_0_00_00_0_1_0_0;
    localparam logic [16:0] E_BRANCH      = 17'b0_1_0_0_0_0_0_0_1_00_01_1_1_0_0;

    multicycle_main_control #(
        .WAIT_LIMIT(4),
        .CNT_W     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .iord         (iord),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .pc_source    (pc_source),
        .instr_done   (instr_done),
        .illegal_instr(illegal_instr),
        .mem_timeout  (mem_timeout),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: drive mem_ready, check state and outputs mid-cycle, advance
    task automatic cyc(input string tag, input logic rdy, input logic [3:0] st,
                       input logic [16:0] vec);
        mem_ready = rdy;
        @(negedge clk);
        check({tag, "_state"}, 32'(state_o), 32'(st));
        check({tag, "_outs"}, 32'(obs_vec), 32'(vec));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 7'b0000011;
        mem_ready = 1'b1;

        // Reset held for two cycles: everything low even though FETCH is loaded
        @(posedge clk);
        @(negedge clk);
        check("rst1_outs", 32'(obs_vec), 32'(E_ZERO));
        check("rst1_state", 32'(state_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst2_outs", 32'(obs_vec), 32'(E_ZERO));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // lw, memory always ready: 0,1,2,3,4
        cyc("lw_fetch", 1'b1, 4'd0, E_FETCH_RDY);
        cyc("lw_decode", 1'b1, 4'd1, E_DECODE);
        cyc("lw_addr", 1'b1, 4'd2, E_MEM_ADDR);
        cyc("lw_read", 1'b1, 4'd3, E_MEM_READ);
        cyc("lw_wb", 1'b1, 4'd4, E_MEM_WB);

        // R-type: 0,1,6,7
        opcode = 7'b0110011;
        cyc("r_fetch", 1'b1, 4'd0, E_FETCH_RDY);
        cyc("r_decode", 1'b1, 4'd1, E_DECODE);
        cyc("r_exec", 1'b1, 4'd6, E_EXEC_R);
        cyc("r_wb", 1'b1, 4'd7, E_R_WB);

        // beq: 0,1,8
        opcode = 7'b1100011;
        cyc("beq_fetch", 1'b1, 4'd0, E_FETCH_RDY);
        cyc("beq_decode", 1'b1, 4'd1, E_DECODE);
        cyc("beq_branch", 1'b1, 4'd8, E_BRANCH);

        // sw with three not-ready cycles; ready arrives exactly on the limit cycle
        opcode = 7'b0100011;
        cyc("sw_fetch", 1'b1, 4'd0, E_FETCH_RDY);
        cyc("sw_decode", 1'b1, 4'd1, E_DECODE);
        cyc("sw_addr", 1'b1, 4'd2, E_MEM_ADDR);
        cyc("sw_wait1", 1'b0, 4'd5, E_MEM_WR_WAIT);
        cyc("sw_wait2", 1'b0, 4'd5, E_MEM_WR_WAIT);
        cyc("sw_wait3", 1'b0, 4'd5, E_MEM_WR_WAIT);
        cyc("sw_ready", 1'b1, 4'd5, E_MEM_WR_RDY);

        // lw with memory stuck low: timeout on the 4th MEM_READ cycle
        opcode = 7'b0000011;
        cyc("to_fetch", 1'b1, 4'd0, E_FETCH_RDY);
        cyc("to_decode", 1'b1, 4'd1, E_DECODE);
        cyc("to_addr", 1'b1, 4'd2, E_MEM_ADDR);
        cyc("to_read1", 1'b0, 4'd3, E_MEM_READ);
        cyc("to_read2", 1'b0, 4'd3, E_MEM_READ);
        cyc("to_read3", 1'b0, 4'd3, E_MEM_READ);
        cyc("to_read4", 1'b0, 4'd3, E_MEM_RD_TMO);

        // Same again but ready on the 4th cycle: normal writeback
        cyc("lim_fetch", 1'b1, 4'd0, E_FETCH_RDY);
        cyc("lim_decode", 1'b1, 4'd1, E_DECODE);
        cyc("lim_addr", 1'b1, 4'd2, E_MEM_ADDR);
        cyc("lim_read1", 1'b0, 4'd3, E_MEM_READ);
        cyc("lim_read2", 1'b0, 4'd3, E_MEM_READ);
        cyc("lim_read3", 1'b0, 4'd3, E_MEM_READ);
        cyc("lim_read4", 1'b1, 4'd3, E_MEM_READ);
        cyc("lim_wb", 1'b1, 4'd4, E_MEM_WB);

        // Fetch timeout restarts the fetch with a fresh count
        cyc("ft_wait1", 1'b0, 4'd0, E_FETCH_WAIT);
        cyc("ft_wait2", 1'b0, 4'd0, E_FETCH_WAIT);
        cyc("ft_wait3", 1'b0, 4'd0, E_FETCH_WAIT);
        cyc("ft_tmo", 1'b0, 4'd0, E_FETCH_TMO);
        cyc("ft_again", 1'b0, 4'd0, E_FETCH_WAIT);
        cyc("ft_ready", 1'b1, 4'd0, E_FETCH_RDY);
        cyc("ft_decode", 1'b1, 4'd1, E_DECODE);
        cyc("ft_addr", 1'b1, 4'd2, E_MEM_ADDR);
        cyc("ft_read", 1'b1, 4'd3, E_MEM_READ);
        cyc("ft_wb", 1'b1, 4'd4, E_MEM_WB);

        // Illegal opcode: pulse in DECODE, back to FETCH
        opcode = 7'b1111111;
        cyc("ill_fetch", 1'b1, 4'd0, E_FETCH_RDY);
        cyc("ill_decode", 1'b1, 4'd1, E_DECODE_ILL);
        opcode = 7'b0110011;
        cyc("ill_next", 1'b1, 4'd0, E_FETCH_RDY);

        // Reset during EXEC_R: outputs drop at once, no R_WB afterwards
        cyc("rr_decode", 1'b1, 4'd1, E_DECODE);
        @(negedge clk);
        check("rr_exec_state", 32'(state_o), 32'd6);
        rst = 1'b1;
        #1;
        check("rr_rst_outs", 32'(obs_vec), 32'(E_ZERO));
        check("rr_rst_state", 32'(state_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("rr_after", 1'b1, 4'd0, E_FETCH_RDY);
        cyc("rr_decode2", 1'b1, 4'd1, E_DECODE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multi-cycle RISC-V core.
- Produces the 2-bit ALUOp consumed by the ALU-control decoder: 00 = add, 01 = subtract/compare, 10 = decode from func7/func3.
- Produces all datapath enables and mux selects for each phase: fetch, decode, execute, memory, writeback.
- Sequences instructions over multiple cycles and waits on a memory-ready handshake, with a bounded-wait timeout.

Parameters:
- WAIT_LIMIT, 16, max cycles a state waits for mem_ready before abort (range 2..255).
- CNT_W, 8, width of the wait counter (must hold WAIT_LIMIT-1).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  instr[6:0] from the instruction register.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op  out  2  to the ALU-control decoder.
- pc_source  out  1  0 = ALU result, 1 = ALUOut.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode.
- mem_timeout  out  1  one-cycle pulse on a wait abort.
- state_o  out  4  current state encoding (debug).

Behaviour:
- Reset:
  - On a clk edge with rst=1: state <= FETCH, wait_cnt <= 0.
  - While rst=1, every output is forced to 0, including state_o.
  - rst mid-instruction aborts it with no further writes.
- Output style: Moore decode of the registered state. Exception: ir_write, pc_write, instr_done, mem_timeout and the wait-state exits are also qualified by mem_ready/wait_cnt in the same cycle. Unlisted outputs are 0.
- States and outputs:
  - FETCH (0):
    - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=0.
    - If mem_ready: ir_write=1, pc_write=1, go to DECODE.
    - Else: stay.
  - DECODE (1):
    - Outputs: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut).
    - Transitions by opcode:
      - 0000011 or 0100011 -> MEM_ADDR.
      - 0110011 -> EXEC_R.
      - 1100011 -> BRANCH.
      - Any other opcode -> FETCH with illegal_instr=1.
  - MEM_ADDR (2):
    - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
    - lw -> MEM_READ; sw -> MEM_WRITE.
    - opcode is held stable by the IR, which is not written outside FETCH.
  - MEM_READ (3):
    - Outputs: mem_read=1, iord=1.
    - If mem_ready -> MEM_WB.
  - MEM_WB (4):
    - Outputs: reg_write=1, mem_to_reg=1, instr_done=1.
    - Next: FETCH.
  - MEM_WRITE (5):
    - Outputs: mem_write=1, iord=1.
    - If mem_ready: instr_done=1, go to FETCH.
  - EXEC_R (6):
    - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
    - Next: R_WB.
  - R_WB (7):
    - Outputs: reg_write=1, mem_to_reg=0, instr_done=1.
    - Next: FETCH.
  - BRANCH (8):
    - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1, instr_done=1.
    - Next: FETCH.
- Latency with mem_ready tied high:
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type: 4 cycles.
  - beq: 3 cycles.
  - Illegal opcode: 2 cycles.
- Wait counter (wait states are FETCH, MEM_READ, MEM_WRITE):
  - wait_cnt increments each cycle spent in a wait state with mem_ready=0.
  - It clears on any state change.
  - If mem_ready=0 and wait_cnt == WAIT_LIMIT-1: mem_timeout=1 for that cycle, next state FETCH, wait_cnt cleared.
  - A timeout in FETCH restarts the fetch. It produces no ir_write and no pc_write.
  - A timeout in MEM_WRITE produces no instr_done.
- Priority: mem_ready=1 on the limit cycle is a normal completion; no timeout.
- Unused state encodings (9..15) go to FETCH on the next edge, with no outputs asserted.

Decomposition:
- Shared package: opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH), ALUOP_ADD/SUB/FUNC encodings, alu_src_b encodings, state enumeration.
- The ALU-control decoder imports the same ALUOp constants.
- One sub-module: mc_wait_timer. Inputs clk, rst, clear, count_en. Outputs expired (wait_cnt == WAIT_LIMIT-1) and cnt.

Test Plan:
- Reset with rst=1 for 2 cycles: all outputs 0. After release: state_o=0, mem_read=1, alu_src_b=01.
- lw (0000011), mem_ready=1: state_o sequence 0,1,2,3,4,0. alu_op=00 throughout. reg_write & mem_to_reg only in state 4. instr_done on cycle 5.
- R-type (0110011): state_o sequence 0,1,6,7,0. alu_op=10 only in state 6. beq (1100011): 0,1,8,0 with alu_op=01, pc_write_cond=1, pc_source=1 in state 8.
- sw with mem_ready low for 3 cycles in MEM_WRITE: mem_write=1 for 4 cycles. instr_done only on the ready cycle. No reg_write.
- WAIT_LIMIT=4, mem_ready stuck 0 in MEM_READ: mem_timeout pulse on the 4th cycle, then FETCH. No reg_write. Repeat with mem_ready=1 on the 4th cycle: normal MEM_WB, no timeout.
- Opcode 1111111 in DECODE: illegal_instr pulse, FETCH next. rst asserted in EXEC_R: outputs 0 at once, FETCH after release, no reg_write.
